draw_scheduler: RTL and testbench

- Sequences line-segment draw commands from NREQ requesters into the single shared line-draw engine that feeds the video path.
- Round-robin arbitration between requesters; valid/ready handshake on both sides.
- Enforces a per-frame command budget, reloaded at each frame start (VSync rising edge).
- Sits between the CPU/test-pattern command sources and the draw engine, in the clk domain alongside the video timing generator.

---
 rtl/draw_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/draw_scheduler.sv | 150 +++++++++++++++
 tb/tb_draw_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared constants for the line-draw command scheduler: command layout,
// FSM state encoding and budget counter width.
package draw_pkg;

    localparam int CMD_W  = 40;
    localparam int X0_LSB = 0;
    localparam int Y0_LSB = 10;
    localparam int X1_LSB = 20;
    localparam int Y1_LSB = 30;
    localparam int BUD_W  = 8;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ISSUE     = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request after ptr,
// wrapping modulo NREQ.
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_req
);

    always_comb begin
        int  idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        any_req   = |req;
        found     = 1'b0;
        idx       = 0;
        // Search ptr+1 first so the previous winner gets lowest priority.
        for (int off = 1; off <= NREQ; off++) begin
            idx = (int'(ptr) + off) % NREQ;
            if (!found && req[idx]) begin
                found          = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/draw_scheduler.sv
// Round-robin scheduler feeding the shared line-draw engine with a per-frame
// command budget. Define DRAW_SCHED_VBLANK_ONLY_EN to accept only in VBlank.
module draw_scheduler #(
    parameter int NREQ  = 4,
    parameter int CMD_W = draw_pkg::CMD_W,
    parameter int BUD_W = draw_pkg::BUD_W,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  vsync,
    input  logic                  vblank,
    input  logic [BUD_W-1:0]      cfg_budget,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*CMD_W-1:0] req_cmd,
    output logic [NREQ-1:0]       req_ready,
    output logic                  eng_valid,
    output logic [CMD_W-1:0]      eng_cmd,
    output logic [IDX_W-1:0]      eng_id,
    input  logic                  eng_ready,
    input  logic                  eng_done,
    output logic                  busy,
    output logic [BUD_W-1:0]      frame_count,
    output logic                  overrun
);
    import draw_pkg::*;

    logic [1:0]       state_q, state_d;
    logic             eng_valid_q, eng_valid_d;
    logic [CMD_W-1:0] eng_cmd_q, eng_cmd_d;
    logic [IDX_W-1:0] eng_id_q, eng_id_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [BUD_W-1:0] budget_left_q, budget_left_d;
    logic [BUD_W-1:0] acc_cnt_q, acc_cnt_d;
    logic [BUD_W-1:0] frame_count_q, frame_count_d;
    logic             overrun_q, overrun_d;
    logic             vsync_q, vsync_d;

    logic [NREQ-1:0]  grant;
    logic [IDX_W-1:0] grant_idx;
    logic             any_req;
    logic             fs;
    logic             open;
    logic             accept;
    logic [BUD_W-1:0] acc_inc;

    rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_req   (any_req)
    );

    assign fs = vsync & ~vsync_q;

`ifdef DRAW_SCHED_VBLANK_ONLY_EN
    assign open = ((cfg_budget == '0) | (budget_left_q != '0)) & vblank;
`else
    logic unused_vblank;
    assign unused_vblank = vblank;
    assign open = (cfg_budget == '0) | (budget_left_q != '0);
`endif

    always_comb begin
        state_d     = state_q;
        eng_valid_d = eng_valid_q;
        eng_cmd_d   = eng_cmd_q;
        eng_id_d    = eng_id_q;
        rr_ptr_d    = rr_ptr_q;
        req_ready   = '0;
        accept      = 1'b0;
        case (state_q)
            IDLE: begin
                if (open && any_req) begin
                    accept      = 1'b1;
                    req_ready   = grant;
                    eng_cmd_d   = req_cmd[int'(grant_idx)*CMD_W +: CMD_W];
                    eng_id_d    = grant_idx;
                    rr_ptr_d    = grant_idx;
                    eng_valid_d = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (eng_ready) begin
                    eng_valid_d = 1'b0;
                    state_d     = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (eng_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_inc       = (acc_cnt_q == {BUD_W{1'b1}}) ? acc_cnt_q : acc_cnt_q + BUD_W'(1);
        budget_left_d = budget_left_q;
        acc_cnt_d     = acc_cnt_q;
        frame_count_d = frame_count_q;
        vsync_d       = vsync;
        overrun_d     = overrun_q | (fs & (state_q != IDLE));
        // An accept coinciding with frame start is billed to the new frame's
        // budget but still reported in the closing frame's count.
        if (fs) begin
            frame_count_d = accept ? acc_inc : acc_cnt_q;
            acc_cnt_d     = accept ? BUD_W'(1) : '0;
            budget_left_d = (accept && cfg_budget != '0) ? cfg_budget - BUD_W'(1) : cfg_budget;
        end else if (accept) begin
            budget_left_d = (budget_left_q != '0) ? budget_left_q - BUD_W'(1) : '0;
            acc_cnt_d     = acc_inc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            eng_valid_q   <= 1'b0;
            eng_cmd_q     <= '0;
            eng_id_q      <= '0;
            rr_ptr_q      <= IDX_W'(NREQ - 1);
            budget_left_q <= '0;
            acc_cnt_q     <= '0;
            frame_count_q <= '0;
            overrun_q     <= 1'b0;
            vsync_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            eng_valid_q   <= eng_valid_d;
            eng_cmd_q     <= eng_cmd_d;
            eng_id_q      <= eng_id_d;
            rr_ptr_q      <= rr_ptr_d;
            budget_left_q <= budget_left_d;
            acc_cnt_q     <= acc_cnt_d;
            frame_count_q <= frame_count_d;
            overrun_q     <= overrun_d;
            vsync_q       <= vsync_d;
        end
    end

    assign eng_valid   = eng_valid_q;
    assign eng_cmd     = eng_cmd_q;
    assign eng_id      = eng_id_q;
    assign busy        = (state_q != IDLE);
    assign frame_count = frame_count_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler: handshake, round-robin order, frame
// budget, frame-start/accept overlap, overrun and async reset.
module tb_draw_scheduler;

    localparam int NREQ  = 4;
    localparam int CMD_W = 40;
    localparam int BUD_W = 8;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  vsync = 1'b0;
    logic                  vblank = 1'b0;
    logic [BUD_W-1:0]      cfg_budget = '0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*CMD_W-1:0] req_cmd = '0;
    logic [NREQ-1:0]       req_ready;
    logic                  eng_valid;
    logic [CMD_W-1:0]      eng_cmd;
    logic [1:0]            eng_id;
    logic                  eng_ready = 1'b0;
    logic                  eng_done = 1'b0;
    logic                  busy;
    logic [BUD_W-1:0]      frame_count;
    logic                  overrun;

    logic [CMD_W-1:0] cmds [NREQ];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    draw_scheduler #(.NREQ(NREQ), .CMD_W(CMD_W), .BUD_W(BUD_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .vsync       (vsync),
        .vblank      (vblank),
        .cfg_budget  (cfg_budget),
        .req_valid   (req_valid),
        .req_cmd     (req_cmd),
        .req_ready   (req_ready),
        .eng_valid   (eng_valid),
        .eng_cmd     (eng_cmd),
        .eng_id      (eng_id),
        .eng_ready   (eng_ready),
        .eng_done    (eng_done),
        .busy        (busy),
        .frame_count (frame_count),
        .overrun     (overrun)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        vsync     = 1'b0;
        req_valid = '0;
        eng_ready = 1'b0;
        eng_done  = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    // Wait for an accept, check it, then run the engine handshake to completion.
    task automatic run_cmd(input int exp_idx);
        bit found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            #1;
            if (req_ready != '0) found = 1;
            else step();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL accept_timeout: no req_ready, expected requester %0d", exp_idx);
            return;
        end
        checks++;
        if (req_ready !== NREQ'(1 << exp_idx)) begin
            errors++;
            $display("FAIL grant: req_ready=%b expected %b", req_ready, NREQ'(1 << exp_idx));
        end
        step();
        checks++;
        if (eng_valid !== 1'b1 || eng_id !== 2'(exp_idx) || eng_cmd !== cmds[exp_idx]) begin
            errors++;
            $display("FAIL issue: valid=%b id=%0d cmd=%h expected 1 %0d %h",
                     eng_valid, eng_id, eng_cmd, exp_idx, cmds[exp_idx]);
        end
        $display("cmd accepted: requester %0d cmd=%h", eng_id, eng_cmd);
        eng_ready = 1'b1;
        step();
        eng_ready = 1'b0;
        step();
        step();
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_done: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({eng_valid, eng_cmd, eng_id, busy, frame_count, overrun, req_ready} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b cmd=%h id=%0d busy=%b fc=%0d ovr=%b rdy=%b expected all 0",
                     eng_valid, eng_cmd, eng_id, busy, frame_count, overrun, req_ready);
        end
        checks++;
        if (dut.rr_ptr_q !== 2'd3) begin
            errors++;
            $display("FAIL reset_rr_ptr: got %0d expected 3", dut.rr_ptr_q);
        end
        do_reset();
        $display("reset checked");
    endtask

    task automatic test_single();
        cfg_budget = 0;
        req_valid  = 4'b0001;
        run_cmd(0);
        req_valid = '0;
    endtask

    task automatic test_round_robin();
        do_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) run_cmd(k % NREQ);
        req_valid = '0;
        step();
    endtask

    task automatic test_budget();
        do_reset();
        cfg_budget = 3;
        req_valid  = 4'b1111;
        vsync      = 1'b1;
        #1;
        checks++;
        if (req_ready !== '0) begin
            errors++;
            $display("FAIL budget_closed_before_fs: req_ready=%b expected 0", req_ready);
        end
        step();
        vsync = 1'b0;
        run_cmd(0);
        run_cmd(1);
        run_cmd(2);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (req_ready !== '0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL budget_exhausted: req_ready=%b busy=%b expected 0 0", req_ready, busy);
            end
            step();
        end
        vsync = 1'b1;
        #1;
        checks++;
        if (req_ready !== '0) begin
            errors++;
            $display("FAIL budget_fs_cycle: req_ready=%b expected 0", req_ready);
        end
        step();
        vsync = 1'b0;
        checks++;
        if (frame_count !== 8'd3) begin
            errors++;
            $display("FAIL frame_count: got %0d expected 3", frame_count);
        end
        $display("frame closed: frame_count=%0d", frame_count);
        run_cmd(3);
    endtask

    task automatic test_fs_with_accept();
        // Continues test_budget: budget_left=2, acc_cnt=1, winner 0 pending.
        cfg_budget = 2;
        vsync      = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL fs_accept_grant: req_ready=%b expected 0001", req_ready);
        end
        step();
        vsync = 1'b0;
        checks++;
        if (frame_count !== 8'd2 || dut.budget_left_q !== 8'd1 || eng_id !== 2'd0) begin
            errors++;
            $display("FAIL fs_accept: frame_count=%0d budget_left=%0d id=%0d expected 2 1 0",
                     frame_count, dut.budget_left_q, eng_id);
        end
        $display("fs with accept: frame_count=%0d", frame_count);
        eng_ready = 1'b1;
        step();
        eng_ready = 1'b0;
        eng_done  = 1'b1;
        step();
        eng_done = 1'b0;
        run_cmd(1);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (req_ready !== '0) begin
                errors++;
                $display("FAIL fs_accept_budget_left: req_ready=%b expected 0", req_ready);
            end
            step();
        end
        req_valid = '0;
    endtask

    task automatic test_overrun_and_reset();
        do_reset();
        cfg_budget = 0;
        req_valid  = 4'b0001;
        step();
        eng_ready = 1'b1;
        step();
        eng_ready = 1'b0;
        req_valid = '0;
        vsync     = 1'b1;
        step();
        vsync = 1'b0;
        checks++;
        if (overrun !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: overrun=%b busy=%b expected 1 1", overrun, busy);
        end
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        checks++;
        if (overrun !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL overrun_sticky: overrun=%b busy=%b expected 1 0", overrun, busy);
        end
        $display("overrun: overrun=%b", overrun);
        req_valid = 4'b0010;
        step();
        checks++;
        if (eng_valid !== 1'b1 || eng_id !== 2'd1 || eng_cmd !== cmds[1]) begin
            errors++;
            $display("FAIL pre_reset_issue: valid=%b id=%0d cmd=%h expected 1 1 %h",
                     eng_valid, eng_id, eng_cmd, cmds[1]);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({eng_valid, eng_cmd, eng_id, busy, frame_count, overrun} !== '0 || dut.rr_ptr_q !== 2'd3) begin
            errors++;
            $display("FAIL mid_issue_reset: valid=%b cmd=%h id=%0d busy=%b fc=%0d ovr=%b ptr=%0d expected zeros ptr 3",
                     eng_valid, eng_cmd, eng_id, busy, frame_count, overrun, dut.rr_ptr_q);
        end
        $display("mid-issue reset applied");
        req_valid = '0;
        step();
        reset_n = 1'b1;
        step();
    endtask

`ifdef DRAW_SCHED_VBLANK_ONLY_EN
    task automatic test_vblank_only();
        do_reset();
        cfg_budget = 0;
        vblank     = 1'b0;
        req_valid  = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (req_ready !== '0) begin
                errors++;
                $display("FAIL vblank_block: req_ready=%b expected 0", req_ready);
            end
            step();
        end
        vblank = 1'b1;
        run_cmd(0);
        req_valid = '0;
        vblank    = 1'b0;
    endtask
`endif

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cmds[0] = 40'h00A_014_0C8_064 & 40'hFF_FFFF_FFFF;
        cmds[0] = 40'h00A0140C8064;
        cmds[1] = 40'h1111111111;
        cmds[2] = 40'h2222233333;
        cmds[3] = 40'h3FF3FF0001;
        req_cmd = {cmds[3], cmds[2], cmds[1], cmds[0]};
        step();
        test_reset();
        test_single();
        test_round_robin();
        test_budget();
        test_fs_with_accept();
        test_overrun_and_reset();
`ifdef DRAW_SCHED_VBLANK_ONLY_EN
        test_vblank_only();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
